datapath_seq: RTL
=================

Name: datapath_seq

Overview:
- Parametrised successor to the single-bus CPU datapath.
- Holds a NUM_REGS x DATA_W register file, a Y operand latch, a Z result latch and an internal ALU.
- A built-in micro-sequencer replaces externally driven Rout/Rin/Yin/Zin strobes. It runs the fixed three-step bus transfer (Rb->Y, Rc/imm->ALU->Z, Z->Ra) on a start/done handshake.
- Sits between the future control unit and memory/IO logic.

Parameters:
- DATA_W, 32, word width in bits; power of two, 8 to 64.
- NUM_REGS, 16, register count; power of two, 4 to 32.
- AW, $clog2(NUM_REGS), register-address width (derived; do not override).

Ports:
- clk, input, 1, rising-edge clock.
- clr, input, 1, reset; asynchronous, active-high; clears all state.
- start, input, 1, request an operation; sampled only in IDLE.
- op, input, 3, operation code (see Behaviour).
- ra, input, AW, destination register.
- rb, input, AW, first source register.
- rc, input, AW, second source register.
- imm, input, DATA_W, immediate operand for ADDI.
- busy, output, 1, high while an operation is in progress.
- done, output, 1, one-cycle pulse when the result is written.
- result, output, DATA_W, copy of Z; holds its value until the next WB.
- flag_z, output, 1, result == 0; updated at WB.
- flag_n, output, 1, result MSB; updated at WB.
- flag_v, output, 1, signed overflow of ADD/SUB/ADDI; cleared by other ops at WB.
- dbg_addr, input, AW, debug read address.
- dbg_data, output, DATA_W, combinational read of register dbg_addr.

Behaviour:
- Reset (clr=1, any time, including mid-operation):
  - State goes to IDLE; all registers, Y and Z clear to 0.
  - busy=0, done=0, result=0, flags=0.
  - The operation in flight is abandoned; no write occurs.
- States: IDLE -> LOADY -> EXEC -> WB -> IDLE.
- IDLE:
  - If start=1 at the edge, latch op/ra/rb/rc/imm and go to LOADY.
  - Inputs are not sampled in any other state. start while busy is ignored and not queued.
- LOADY: Y <= R[rb].
- EXEC: Z <= ALU(Y, B).
  - B = imm for ADDI; B = R[rc] otherwise.
- WB:
  - R[ra] <= Z; result and flags update; done=1 for this cycle only.
  - Next state is IDLE; a new start is accepted the cycle after WB at the earliest.
- busy = 1 in LOADY, EXEC and WB.
- Latency: start edge at cycle 0 -> done high during cycle 3. Throughput is one operation per 4 cycles.
- op encoding:
  - 000 ADD: Y+B.
  - 001 SUB: Y-B.
  - 010 AND.
  - 011 OR.
  - 100 SHL: Y << B[log2(DATA_W)-1:0].
  - 101 SHR: logical right shift, same shift-amount rule.
  - 110 ADDI: Y+imm.
  - 111 MOV: Z = Y.
- Arithmetic wraps modulo 2^DATA_W. Shift amount is always < DATA_W. flag_v uses two's-complement overflow rules.
- R0:
  - Always reads 0 (as source, on dbg_data, and into Y).
  - Writes to R0 are discarded, but result and flags still update and done still pulses.
- ra==rb or ra==rc is legal: sources are read in LOADY/EXEC before the WB write.
- dbg_data during WB to the same address shows the old value; the new value appears the cycle after.

Optional Feature:
- Macro DATAPATH_SAT_EN.
- Defined: ADD, SUB and ADDI saturate on signed overflow to 0x7FF..F (positive) or 0x800..0 (negative). flag_v is still set.
- Undefined: these ops wrap; flag_v is still set. All other ops are identical in both builds.

Test Plan:
- Reset mid-operation:
  - Setup: write R1=5 via ADDI rb=0 imm=5 ra=1.
  - Stimulus: start SUB, then assert clr during EXEC.
  - Required: busy=0 and done=0 immediately; dbg R1=0; next start is accepted normally.
- ADD latency and register write:
  - Setup: R2=0x0000_0003, R3=0x0000_0004.
  - Stimulus: ADD ra=4 rb=2 rc=3.
  - Required: done exactly 3 cycles after the start edge; R4=7, flag_z=0, flag_n=0, flag_v=0.
- Overflow:
  - Setup: R1=0x7FFF_FFFF.
  - Stimulus: ADDI imm=1 ra=5 rb=1.
  - Required, without macro: R5=0x8000_0000, flag_v=1, flag_n=1.
  - Required, with DATAPATH_SAT_EN: R5=0x7FFF_FFFF, flag_v=1, flag_n=0.
- R0 behaviour:
  - Stimulus: ADDI ra=0 rb=0 imm=9.
  - Required: dbg R0=0, result=9, done pulses.
  - Stimulus: MOV ra=6 rb=0.
  - Required: R6=0, flag_z=1.
- Shifts:
  - Setup: R1=0x8000_0001, R2=0x0000_0021 (shift amount 1 after masking).
  - Stimulus: SHL ra=3 rb=1 rc=2.
  - Required: R3=0x0000_0002.
  - Stimulus: SHR ra=3 rb=1 rc=2.
  - Required: R3=0x4000_0000.
- Busy rejection and aliasing:
  - Stimulus: hold start=1 for 8 cycles with SUB ra=1 rb=1 rc=1, R1=10.
  - Required: exactly 2 done pulses, 4 cycles apart; R1=0 after the first, flag_z=1.

Source files
------------

// File: rtl/datapath_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | datapath_seq: register file + Y/Z latches + ALU driven by a built-in        |
// | LOADY/EXEC/WB micro-sequencer. DATAPATH_SAT_EN: saturating ADD/SUB/ADDI.    |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module datapath_seq #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16,
  parameter int AW       = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [AW-1:0]     ra,
  input  logic [AW-1:0]     rb,
  input  logic [AW-1:0]     rc,
  input  logic [DATA_W-1:0] imm,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              flag_z,
  output logic              flag_n,
  output logic              flag_v,
  input  logic [AW-1:0]     dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int SHW = $clog2(DATA_W);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_SHL  = 3'b100;
  localparam logic [2:0] OP_SHR  = 3'b101;
  localparam logic [2:0] OP_ADDI = 3'b110;
  localparam logic [2:0] OP_MOV  = 3'b111;

`ifdef DATAPATH_SAT_EN
  localparam logic [DATA_W-1:0] MAX_POS = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOADY = 2'd1,
    S_EXEC  = 2'd2,
    S_WB    = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] y_q, z_q, result_q, imm_q;
  logic [2:0]        op_q;
  logic [AW-1:0]     ra_q, rb_q, rc_q;
  logic              v_q, flag_z_q, flag_n_q, flag_v_q;

  logic [DATA_W-1:0] rb_val, rc_val, alu_b, alu_sum, alu_diff, alu_res;
  logic              alu_v;

  // R0 is hard-wired to zero on every read port.
  assign rb_val   = (rb_q == '0)     ? '0 : regs_q[rb_q];
  assign rc_val   = (rc_q == '0)     ? '0 : regs_q[rc_q];
  assign dbg_data = (dbg_addr == '0) ? '0 : regs_q[dbg_addr];

  assign result = result_q;
  assign flag_z = flag_z_q;
  assign flag_n = flag_n_q;
  assign flag_v = flag_v_q;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b1;
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_d = S_LOADY;
      end
      S_LOADY: state_d = S_EXEC;
      S_EXEC:  state_d = S_WB;
      S_WB: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    alu_b    = (op_q == OP_ADDI) ? imm_q : rc_val;
    alu_sum  = y_q + alu_b;
    alu_diff = y_q - alu_b;
    alu_res  = '0;
    alu_v    = 1'b0;
    case (op_q)
      OP_ADD, OP_ADDI: begin
        alu_res = alu_sum;
        alu_v   = (y_q[DATA_W-1] == alu_b[DATA_W-1]) && (alu_sum[DATA_W-1] != y_q[DATA_W-1]);
      end
      OP_SUB: begin
        alu_res = alu_diff;
        alu_v   = (y_q[DATA_W-1] != alu_b[DATA_W-1]) && (alu_diff[DATA_W-1] != y_q[DATA_W-1]);
      end
      OP_AND:  alu_res = y_q & alu_b;
      OP_OR:   alu_res = y_q | alu_b;
      OP_SHL:  alu_res = y_q << alu_b[SHW-1:0];
      OP_SHR:  alu_res = y_q >> alu_b[SHW-1:0];
      OP_MOV:  alu_res = y_q;
      default: alu_res = '0;
    endcase
`ifdef DATAPATH_SAT_EN
    // On overflow the true result has the sign of Y for both add and subtract.
    if (alu_v) alu_res = y_q[DATA_W-1] ? MIN_NEG : MAX_POS;
`endif
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      y_q      <= '0;
      z_q      <= '0;
      v_q      <= 1'b0;
      result_q <= '0;
      flag_z_q <= 1'b0;
      flag_n_q <= 1'b0;
      flag_v_q <= 1'b0;
      op_q     <= '0;
      ra_q     <= '0;
      rb_q     <= '0;
      rc_q     <= '0;
      imm_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            op_q  <= op;
            ra_q  <= ra;
            rb_q  <= rb;
            rc_q  <= rc;
            imm_q <= imm;
          end
        end
        S_LOADY: y_q <= rb_val;
        S_EXEC: begin
          z_q <= alu_res;
          v_q <= alu_v;
        end
        S_WB: begin
          if (ra_q != '0) regs_q[ra_q] <= z_q;
          result_q <= z_q;
          flag_z_q <= (z_q == '0);
          flag_n_q <= z_q[DATA_W-1];
          flag_v_q <= v_q;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
